// File: rtl/pipe_hazard_chain_pkg.sv
// Shared widths, register-zero constant and per-stage record for the hazard/forwarding chain.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W   = 32;
  localparam int unsigned PIPE_DEPTH    = 3;
  localparam int unsigned PIPE_RN_W     = 5;
  localparam int unsigned PIPE_LOAD_LAT = 1;

  localparam int unsigned RN_ZERO = 0;

  typedef struct packed {
    logic                   valid;
    logic                   wreg;
    logic                   load;
    logic [PIPE_RN_W-1:0]   rn;
    logic [PIPE_DATA_W-1:0] pay;
  } pipe_stage_t;

endpackage

// File: rtl/pipe_hazard_chain_if.sv
// Issue/forward/writeback bundle between the CPU datapath and the hazard chain.
interface pipe_hazard_chain_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned RN_W   = PIPE_RN_W,
  parameter int unsigned DEPTH  = PIPE_DEPTH
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_wreg;
  logic                    in_load;
  logic [RN_W-1:0]         in_rn;
  logic [DATA_W-1:0]       in_data;
  logic [RN_W-1:0]         src_a;
  logic [RN_W-1:0]         src_b;
  logic                    use_a;
  logic                    use_b;
  logic [DEPTH-1:0]        upd_we;
  logic [DEPTH*DATA_W-1:0] upd_data;
  logic [DEPTH-1:0]        flush_mask;
  logic                    fwd_a_hit;
  logic                    fwd_b_hit;
  logic [DATA_W-1:0]       fwd_a_data;
  logic [DATA_W-1:0]       fwd_b_data;
  logic                    stall;
  logic                    wb_we;
  logic [RN_W-1:0]         wb_rn;
  logic [DATA_W-1:0]       wb_data;
  logic [DEPTH-1:0]        stage_valid;

  modport master (
    output in_valid, in_wreg, in_load, in_rn, in_data, src_a, src_b, use_a, use_b,
           upd_we, upd_data, flush_mask,
    input  in_ready, fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, stall,
           wb_we, wb_rn, wb_data, stage_valid
  );

  modport slave (
    input  in_valid, in_wreg, in_load, in_rn, in_data, src_a, src_b, use_a, use_b,
           upd_we, upd_data, flush_mask,
    output in_ready, fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, stall,
           wb_we, wb_rn, wb_data, stage_valid
  );
endinterface

// File: rtl/pipe_hazard_chain_fwd_sel.sv
// Priority match of one source register against all chain stages; youngest match wins.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = PIPE_DATA_W,
  parameter int unsigned DEPTH    = PIPE_DEPTH,
  parameter int unsigned RN_W     = PIPE_RN_W,
  parameter int unsigned LOAD_LAT = PIPE_LOAD_LAT
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0]             i_wreg,
  input  logic [DEPTH-1:0]             i_load,
  input  logic [DEPTH-1:0][RN_W-1:0]   i_rn,
  input  logic [DEPTH-1:0][DATA_W-1:0] i_eff,
  input  logic [RN_W-1:0]              i_src,
  input  logic                         i_use,
  output logic                         o_hit,
  output logic                         o_stall,
  output logic [DATA_W-1:0]            o_data
);

  always_comb begin
    o_hit   = 1'b0;
    o_stall = 1'b0;
    o_data  = '0;
    // Scan oldest to youngest so a younger match overrides an older one.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_use && (i_src != RN_W'(RN_ZERO)) && i_valid[DEPTH-1-i] &&
          i_wreg[DEPTH-1-i] && (i_rn[DEPTH-1-i] == i_src)) begin
        if (i_load[DEPTH-1-i] && ((DEPTH-1-i) < LOAD_LAT)) begin
          o_hit   = 1'b0;
          o_stall = 1'b1;
          o_data  = '0;
        end else begin
          o_hit   = 1'b1;
          o_stall = 1'b0;
          o_data  = i_eff[DEPTH-1-i];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_chain.sv
// DEPTH-stage hazard/forwarding chain with load-use stall, flush and writeback port.
// Optional event counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_chain
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = PIPE_DATA_W,
  parameter int unsigned DEPTH    = PIPE_DEPTH,
  parameter int unsigned RN_W     = PIPE_RN_W,
  parameter int unsigned LOAD_LAT = PIPE_LOAD_LAT
) (
  input  logic              clk,
  input  logic              clrn,
  pipe_hazard_chain_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              load;
    logic [RN_W-1:0]   rn;
    logic [DATA_W-1:0] pay;
  } stage_t;

  stage_t                      r_stage [DEPTH];
  logic [DEPTH-1:0]            w_valid;
  logic [DEPTH-1:0]            w_wreg;
  logic [DEPTH-1:0]            w_load;
  logic [DEPTH-1:0][RN_W-1:0]  w_rn;
  logic [DEPTH-1:0][DATA_W-1:0] w_eff;
  logic                        w_stall_a;
  logic                        w_stall_b;
  logic                        w_stall;
  logic                        w_issue;

  always_comb begin
    w_valid = '0;
    w_wreg  = '0;
    w_load  = '0;
    w_rn    = '0;
    w_eff   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_valid[k] = r_stage[k].valid;
      w_wreg[k]  = r_stage[k].wreg;
      w_load[k]  = r_stage[k].load;
      w_rn[k]    = r_stage[k].rn;
      w_eff[k]   = bus.upd_we[k] ? bus.upd_data[k*DATA_W +: DATA_W] : r_stage[k].pay;
    end
  end

  pipe_fwd_sel #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RN_W(RN_W), .LOAD_LAT(LOAD_LAT)) u_fwd_a (
    .i_valid(w_valid), .i_wreg(w_wreg), .i_load(w_load), .i_rn(w_rn), .i_eff(w_eff),
    .i_src(bus.src_a), .i_use(bus.use_a),
    .o_hit(bus.fwd_a_hit), .o_stall(w_stall_a), .o_data(bus.fwd_a_data)
  );

  pipe_fwd_sel #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RN_W(RN_W), .LOAD_LAT(LOAD_LAT)) u_fwd_b (
    .i_valid(w_valid), .i_wreg(w_wreg), .i_load(w_load), .i_rn(w_rn), .i_eff(w_eff),
    .i_src(bus.src_b), .i_use(bus.use_b),
    .o_hit(bus.fwd_b_hit), .o_stall(w_stall_b), .o_data(bus.fwd_b_data)
  );

  assign w_stall         = bus.in_valid & (w_stall_a | w_stall_b);
  assign w_issue         = bus.in_valid & ~w_stall;
  assign bus.stall       = w_stall;
  assign bus.in_ready    = ~w_stall;
  assign bus.stage_valid = w_valid;
  assign bus.wb_we       = w_valid[DEPTH-1] & w_wreg[DEPTH-1] & (w_rn[DEPTH-1] != RN_W'(RN_ZERO));
  assign bus.wb_rn       = w_rn[DEPTH-1];
  assign bus.wb_data     = w_eff[DEPTH-1];

  // Flush masks the valid bit only; the other fields still shift so they stay deterministic.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= '{valid: w_issue & ~bus.flush_mask[0], wreg: bus.in_wreg,
                      load: bus.in_load, rn: bus.in_rn, pay: bus.in_data};
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_stage[k] <= '{valid: r_stage[k-1].valid & ~bus.flush_mask[k], wreg: r_stage[k-1].wreg,
                        load: r_stage[k-1].load, rn: r_stage[k-1].rn, pay: w_eff[k-1]};
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [DEPTH-1:0] w_enter;
  logic [31:0]      r_perf_issued;
  logic [31:0]      r_perf_stall;
  logic [31:0]      r_perf_flush;

  always_comb begin
    w_enter    = '0;
    w_enter[0] = w_issue;
    for (int unsigned k = 1; k < DEPTH; k++) w_enter[k] = r_stage[k-1].valid;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
      r_perf_flush  <= '0;
    end else begin
      r_perf_issued <= r_perf_issued + 32'(w_issue);
      r_perf_stall  <= r_perf_stall + 32'(w_stall);
      r_perf_flush  <= r_perf_flush + 32'(|(w_enter & bus.flush_mask));
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
  assign perf_flush  = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Scoreboard bench for pipe_hazard_chain (DEPTH=3, LOAD_LAT=1) with directed vectors.
module tb_pipe_hazard_chain;

  localparam int unsigned DW = 32;
  localparam int unsigned D  = 3;
  localparam int unsigned RW = 5;

  localparam int S_AHIT = 0, S_ADATA = 1, S_STALL = 2, S_READY = 3, S_WBWE = 4,
                 S_WBRN = 5, S_WBDATA = 6, S_SVALID = 7, S_BHIT = 8, S_BDATA = 9,
                 S_PISS = 10, S_PSTL = 11, S_PFLS = 12;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pipe_hazard_chain_if #(.DATA_W(DW), .RN_W(RW), .DEPTH(D)) bus ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_flush;
`endif

  pipe_hazard_chain #(.DATA_W(DW), .DEPTH(D), .RN_W(RW), .LOAD_LAT(1)) dut (
    .clk(clk),
    .clrn(clrn),
    .bus(bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] get_act(int sel);
    case (sel)
      S_AHIT:   return 32'(bus.fwd_a_hit);
      S_ADATA:  return bus.fwd_a_data;
      S_STALL:  return 32'(bus.stall);
      S_READY:  return 32'(bus.in_ready);
      S_WBWE:   return 32'(bus.wb_we);
      S_WBRN:   return 32'(bus.wb_rn);
      S_WBDATA: return bus.wb_data;
      S_SVALID: return 32'(bus.stage_valid);
      S_BHIT:   return 32'(bus.fwd_b_hit);
      S_BDATA:  return bus.fwd_b_data;
`ifdef PIPE_HAZARD_PERF_EN
      S_PISS:   return perf_issued;
      S_PSTL:   return perf_stall;
      S_PFLS:   return perf_flush;
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every expectation queued for the current cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
      exp_t e;
      logic [31:0] act;
      e = sb_q.pop_front();
      act = get_act(e.sel);
      total++;
      if (e.cyc != cycle) begin
        bad++;
        $display("FAIL %s: not sampled in cycle %0d (now %0d)", e.name, e.cyc, cycle);
      end else if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.exp, cycle);
      end
    end
  end

  task automatic expect_v(int sel, logic [31:0] e, string nm);
    exp_t x;
    x.cyc = cycle; x.sel = sel; x.exp = e; x.name = nm;
    sb_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_wreg = 1'b0; bus.in_load = 1'b0; bus.in_rn = '0;
    bus.in_data = '0; bus.src_a = '0; bus.src_b = '0; bus.use_a = 1'b0; bus.use_b = 1'b0;
    bus.upd_we = '0; bus.upd_data = '0; bus.flush_mask = '0;
  endtask

  task automatic issue(logic wreg, logic load, logic [RW-1:0] rn, logic [DW-1:0] data);
    bus.in_valid = 1'b1; bus.in_wreg = wreg; bus.in_load = load;
    bus.in_rn = rn; bus.in_data = data;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    idle();
    step();
    expect_v(S_STALL, 0, "rst_stall");
    expect_v(S_READY, 1, "rst_ready");
    expect_v(S_AHIT, 0, "rst_ahit");
    expect_v(S_ADATA, 0, "rst_adata");
    expect_v(S_WBWE, 0, "rst_wbwe");
    expect_v(S_WBRN, 0, "rst_wbrn");
    expect_v(S_WBDATA, 0, "rst_wbdata");
    expect_v(S_SVALID, 0, "rst_svalid");
    step();
    clrn = 1'b1;
    step();

    // Back-to-back ALU dependence on r3.
    issue(1, 0, 5'd3, 32'h100);
    step();
    issue(0, 0, 5'd9, 32'h0);
    bus.src_a = 5'd3; bus.use_a = 1'b1; bus.src_b = 5'd3; bus.use_b = 1'b0;
    bus.upd_we = 3'b001; bus.upd_data[0 +: 32] = 32'h11;
    expect_v(S_AHIT, 1, "alu_ahit");
    expect_v(S_ADATA, 32'h11, "alu_adata");
    expect_v(S_STALL, 0, "alu_stall");
    expect_v(S_BHIT, 0, "alu_unused_bhit");
    step();
    bus.upd_we = '0; bus.upd_data = '0; bus.use_b = 1'b0;
    expect_v(S_AHIT, 1, "alu_s1_ahit");
    expect_v(S_ADATA, 32'h11, "alu_s1_adata");
    step();
    idle();
    expect_v(S_WBWE, 1, "alu_wbwe");
    expect_v(S_WBRN, 3, "alu_wbrn");
    expect_v(S_WBDATA, 32'h11, "alu_wbdata");
    drain();

    // Load-use on r4: one stall cycle, then forward from stage 1.
    issue(1, 1, 5'd4, 32'h0);
    step();
    issue(0, 0, 5'd0, 32'h0);
    bus.src_a = 5'd4; bus.use_a = 1'b1;
    expect_v(S_STALL, 1, "lu_stall");
    expect_v(S_READY, 0, "lu_ready");
    expect_v(S_AHIT, 0, "lu_ahit");
    expect_v(S_SVALID, 3'b001, "lu_svalid");
    step();
    bus.upd_we = 3'b010; bus.upd_data[32 +: 32] = 32'hABCD;
    expect_v(S_STALL, 0, "lu2_stall");
    expect_v(S_READY, 1, "lu2_ready");
    expect_v(S_AHIT, 1, "lu2_ahit");
    expect_v(S_ADATA, 32'hABCD, "lu2_adata");
    expect_v(S_SVALID, 3'b010, "lu2_svalid");
    step();
    idle();
    expect_v(S_SVALID, 3'b101, "lu3_svalid");
    expect_v(S_WBWE, 1, "lu3_wbwe");
    expect_v(S_WBRN, 4, "lu3_wbrn");
    expect_v(S_WBDATA, 32'hABCD, "lu3_wbdata");
    drain();

    // Priority: r5 in stage 2 (0x1) and stage 1 (0x2).
    issue(1, 0, 5'd5, 32'h1);
    step();
    issue(1, 0, 5'd5, 32'h2);
    step();
    idle();
    step();
    issue(0, 0, 5'd0, 32'h0);
    bus.src_a = 5'd5; bus.use_a = 1'b1; bus.src_b = 5'd5; bus.use_b = 1'b1;
    expect_v(S_AHIT, 1, "pri_ahit");
    expect_v(S_ADATA, 32'h2, "pri_adata");
    expect_v(S_BHIT, 1, "pri_bhit");
    expect_v(S_BDATA, 32'h2, "pri_bdata");
    expect_v(S_SVALID, 3'b110, "pri_svalid");
    expect_v(S_WBDATA, 32'h1, "pri_wbdata");
    step();
    drain();

    // Register zero is never forwarded nor written.
    issue(1, 0, 5'd0, 32'h77);
    step();
    issue(0, 0, 5'd0, 32'h0);
    bus.src_a = 5'd0; bus.use_a = 1'b1;
    expect_v(S_AHIT, 0, "r0_ahit");
    expect_v(S_ADATA, 0, "r0_adata");
    step();
    idle();
    step();
    expect_v(S_SVALID, 3'b110, "r0_svalid");
    expect_v(S_WBWE, 0, "r0_wbwe");
    drain();

    // Flush of stage 0 and stage 1.
    issue(0, 0, 5'd0, 32'h0);
    step();
    issue(1, 0, 5'd7, 32'h55);
    bus.flush_mask = 3'b001;
    step();
    bus.flush_mask = '0;
    issue(1, 0, 5'd8, 32'h66);
    bus.src_a = 5'd7; bus.use_a = 1'b1;
    expect_v(S_AHIT, 0, "fl_ahit");
    expect_v(S_SVALID, 3'b010, "fl_svalid0");
    step();
    idle();
    bus.flush_mask = 3'b010;
    bus.src_a = 5'd8; bus.use_a = 1'b1;
    expect_v(S_AHIT, 1, "fl_pre_ahit");
    expect_v(S_ADATA, 32'h66, "fl_pre_adata");
    expect_v(S_SVALID, 3'b101, "fl_svalid1");
    expect_v(S_WBWE, 0, "fl_branch_wbwe");
    step();
    idle();
    expect_v(S_SVALID, 3'b000, "fl_svalid2");
    expect_v(S_WBWE, 0, "fl_killed_wbwe");
    drain();

    // Reset with three instructions in flight.
    issue(1, 0, 5'd9, 32'h9);
    step();
    issue(1, 0, 5'd10, 32'hA);
    step();
    issue(1, 0, 5'd11, 32'hB);
    expect_v(S_SVALID, 3'b011, "rs_svalid_pre");
    step();
    idle();
    clrn = 1'b0;
    #1;
    expect_v(S_SVALID, 0, "rs_svalid");
    expect_v(S_WBWE, 0, "rs_wbwe");
    expect_v(S_READY, 1, "rs_ready");
`ifdef PIPE_HAZARD_PERF_EN
    expect_v(S_PISS, 0, "rs_perf_issued");
    expect_v(S_PSTL, 0, "rs_perf_stall");
    expect_v(S_PFLS, 0, "rs_perf_flush");
`endif
    step();
    expect_v(S_SVALID, 0, "rs_svalid_hold");
    clrn = 1'b1;
    step();
    expect_v(S_WBWE, 0, "rs_wbwe_after");
    expect_v(S_SVALID, 0, "rs_svalid_after");
    repeat (3) step();

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never sampled (queued for cycle %0d)", e.name, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_chain.md
Name: pipe_hazard_chain

Overview:
- Parametrised hazard and forwarding backbone for the in-order pipelined CPU.
- Replaces the fixed EXE/MEM/WB register trio and the hard-wired hazard logic with one DEPTH-stage chain. Each stage tracks valid, write-enable, load flag, destination register and payload.
- Resolves operand forwarding and load-use stalls for any depth and load latency, supports per-stage flush, and drives the register-file write port from the last stage.

Parameters:
- DATA_W, 32, payload/operand width
- DEPTH, 3, number of post-issue stages; stage 0 = EXE-equivalent, DEPTH-1 = writeback; legal range 2..8
- RN_W, 5, register-number width; register 0 is never written and never forwarded
- LOAD_LAT, 1, a load in stage k < LOAD_LAT has no data yet; legal 0..DEPTH-1

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- in_valid  in  1  instruction presented at issue
- in_ready  out  1  issue accepted this cycle; equals !stall
- in_wreg  in  1  instruction writes a register
- in_load  in  1  instruction result comes from memory
- in_rn  in  RN_W  destination register
- in_data  in  DATA_W  initial payload, e.g. pc4 for link
- src_a, src_b  in  RN_W  source registers of the issuing instruction
- use_a, use_b  in  1  source is actually read
- upd_we  in  DEPTH  stage k produces its result this cycle
- upd_data  in  DEPTH*DATA_W  result of stage k in slice [k*DATA_W +: DATA_W]
- flush_mask  in  DEPTH  bit k kills the instruction entering stage k at the next edge
- fwd_a_hit, fwd_b_hit  out  1  operand must come from fwd_*_data instead of the register file
- fwd_a_data, fwd_b_data  out  DATA_W  forwarded operand
- stall  out  1  load-use hazard; issue is held
- wb_we  out  1  register-file write enable
- wb_rn  out  RN_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- stage_valid  out  DEPTH  per-stage valid, for debug

Behaviour:
- Reset, asynchronous on clrn=0: all stage valid, wreg, load, rn and payload registers = 0. Consequently stall=0, in_ready=1, fwd_*_hit=0, fwd_*_data=0, wb_we=0, wb_rn=0, wb_data=0.
- Chain always advances; there is no back-pressure from later stages.
- Effective stage value: eff[k] = upd_we[k] ? upd_data[k] : pay[k].
- Shift on each clock edge, for k≥1: stage k ← stage k-1, with pay[k] ← eff[k-1].
- Stage 0 on each clock edge:
  - Loads the issuing instruction when in_valid && !stall, with pay[0] ← in_data.
  - Otherwise loads a bubble (valid=0).
- Flush: after the shift, valid[k] ← 0 wherever flush_mask[k]=1. Flush has priority over both issue and shift.
- Match condition for source s at stage k: valid[k] && wreg[k] && rn[k]==s && s!=0.
- Hit: the lowest matching k (the youngest stage) wins.
- Forwarding result, per source, when use_*=1 and a matching stage k exists:
  - If load[k] && k<LOAD_LAT: that source raises stall; fwd_*_hit=0.
  - Otherwise fwd_*_hit=1 and fwd_*_data=eff[k].
- No match, or use_*=0: fwd_*_hit=0 and fwd_*_data=0.
- stall = stall_a | stall_b, qualified by in_valid. stall is combinational; it takes effect at the next edge by inserting a bubble into stage 0.
- Writeback: stage DEPTH-1 drives the register-file port.
  - wb_we = valid && wreg && rn!=0
  - wb_rn = rn
  - wb_data = eff[DEPTH-1]
- The writeback stage is also a forwarding source. This covers a same-cycle register-file read and write.
- Flushed or bubble stages never match, never stall and never write.
- Reset asserted mid-stream discards all in-flight instructions; there is no partial writeback.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- When defined, three 32-bit counters, each reset to 0 by clrn and wrapping silently at 2^32:
  - perf_issued: +1 per accepted issue
  - perf_stall: +1 per cycle with stall=1
  - perf_flush: +1 per edge on which flush_mask kills at least one valid instruction
- The counters are exposed on output ports perf_issued, perf_stall and perf_flush.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg: the per-stage record type (valid, wreg, load, rn, payload), the RN_ZERO constant and the default widths.
- One sub-module, pipe_fwd_sel: combinational priority match over DEPTH stages for one source. It returns hit, stall and data, and is instantiated twice (a and b).

Test Plan:
- Back-to-back ALU dependence, DEPTH=3: issue writes r3 (upd_we[0], upd_data[0]=0x11), next issue reads r3 → fwd_a_hit=1, fwd_a_data=0x11, stall=0.
- Load-use, LOAD_LAT=1: load r4 issued, next issue uses r4 → stall=1 for exactly one cycle, bubble in stage 0. The cycle after, the load is in stage 1 with upd_data[1]=0xABCD → fwd_a_data=0xABCD, in_ready=1.
- Priority: r5 written by instructions in stage 2 (0x1) and stage 1 (0x2), reader of r5 → fwd_a_data=0x2.
- Register zero: instruction writes r0, reader uses src_a=0 → fwd_a_hit=0, and 3 cycles later wb_we=0.
- Flush: flush_mask=3'b001 while a branch resolves → the killed instruction never sets wb_we, and stage_valid shows a bubble propagating.
- Reset mid-stream: clrn pulsed low while 3 instructions are in flight → stage_valid=0 immediately, with no wb_we for those instructions. With PIPE_HAZARD_PERF_EN defined, all three counters read 0.
